// File: rtl/autoconfig_master.sv
// Zorro II AutoConfig enumerator: walks the $E80000 config chain over a 68000-style bus,
// assigns naturally aligned bases from the memory or I/O window, and shuts up boards that do not fit.
module autoconfig_master #(
    parameter int         MAX_BOARDS = 8,
    parameter int         TIMEOUT    = 64,
    parameter logic [7:0] MEM_BASE   = 8'h20,
    parameter logic [7:0] MEM_LIMIT  = 8'hA0,
    parameter logic [7:0] IO_BASE    = 8'hE9,
    parameter logic [7:0] IO_LIMIT   = 8'hF0
) (
    input  logic        CPU_CLK,
    input  logic        RESET,
    input  logic        START,
    output logic [22:0] ADDRESS,
    output logic        CPU_RW,
    output logic        CPU_AS,
    output logic        CPU_UDS,
    output logic        CPU_LDS,
    input  logic        DTACK,
    input  logic [3:0]  DATA_IN,
    output logic [3:0]  DATA_OUT,
    output logic        DATA_OE,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  BOARD_COUNT,
    output logic [3:0]  SHUTUP_COUNT,
    output logic [7:0]  PRODUCT
);

    localparam int             TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMEOUT_CNT = TW'(TIMEOUT);
    localparam logic [4:0]     MAX_CNT     = 5'(MAX_BOARDS);

    typedef enum logic [3:0] {
        IDLE, RD_T0, RD_T1, RD_P0, RD_P1, ALLOC, WR_LO, WR_HI, WR_SHUT, FIN
    } state_e;

    typedef enum logic [2:0] {
        PH_ADDR, PH_AS, PH_UDS, PH_WAIT, PH_NEG, PH_END
    } phase_e;

    state_e          state, nxt_state;
    phase_e          phase;
    logic [TW-1:0]   tcnt;
    logic            timed_out;
    logic            dtack_m, dtack_s;
    logic            start_armed;
    logic [3:0]      type_hi, type_lo;
    logic [8:0]      mem_ptr, io_ptr;
    logic [7:0]      base_reg;

    logic [7:0]      er_type;
    logic            type_ok, pool_mem, fits, limit_hit;
    logic [8:0]      ptr, limit, size, align_mask, base, next_ptr;
    logic [3:0]      wdata;

    assign CPU_LDS = 1'b1;

    function automatic logic is_write(input state_e s);
        return (s == WR_LO) || (s == WR_HI) || (s == WR_SHUT);
    endfunction

    // A23:A16 = $E8, A7:A1 = register word offset, everything else zero.
    function automatic logic [22:0] bus_addr(input state_e s);
        logic [6:0] word;
        logic       access;
        word   = 7'h00;
        access = 1'b1;
        case (s)
            RD_T0:   word = 7'h00;
            RD_T1:   word = 7'h01;
            RD_P0:   word = 7'h02;
            RD_P1:   word = 7'h03;
            WR_LO:   word = 7'h25;
            WR_HI:   word = 7'h24;
            WR_SHUT: word = 7'h26;
            default: access = 1'b0;
        endcase
        return access ? {8'hE8, 8'h00, word} : 23'd0;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        er_type    = {type_hi, type_lo};
        type_ok    = (er_type[7:6] == 2'b11) && (er_type != 8'hFF);
        pool_mem   = er_type[5];
        ptr        = pool_mem ? mem_ptr : io_ptr;
        limit      = pool_mem ? {1'b0, MEM_LIMIT} : {1'b0, IO_LIMIT};
        // 8MB boards align to 2MB so one can still land at the start of the memory window.
        if (er_type[2:0] == 3'b000) begin
            size       = 9'd128;
            align_mask = 9'd31;
        end else begin
            size       = 9'd1 << (er_type[2:0] - 3'd1);
            align_mask = size - 9'd1;
        end
        base       = (ptr + align_mask) & ~align_mask;
        next_ptr   = base + size;
        fits       = next_ptr <= limit;
        limit_hit  = ({1'b0, BOARD_COUNT} + {1'b0, SHUTUP_COUNT} + 5'd1) == MAX_CNT;

        wdata = 4'h0;
        case (state)
            WR_LO:   wdata = base_reg[3:0];
            WR_HI:   wdata = base_reg[7:4];
            default: wdata = 4'h0;
        endcase

        nxt_state = IDLE;
        case (state)
            IDLE:    nxt_state = RD_T0;
            RD_T0:   nxt_state = timed_out ? FIN : RD_T1;
            RD_T1:   nxt_state = (timed_out || !type_ok) ? FIN : RD_P0;
            RD_P0:   nxt_state = timed_out ? FIN : RD_P1;
            RD_P1:   nxt_state = timed_out ? FIN : ALLOC;
            ALLOC:   nxt_state = fits ? WR_LO : WR_SHUT;
            WR_LO:   nxt_state = timed_out ? FIN : WR_HI;
            WR_HI,
            WR_SHUT: nxt_state = (timed_out || limit_hit) ? FIN : RD_T0;
            FIN:     nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK) begin
        if (!RESET) begin
            state        <= IDLE;
            phase        <= PH_ADDR;
            tcnt         <= '0;
            timed_out    <= 1'b0;
            dtack_m      <= 1'b1;
            dtack_s      <= 1'b1;
            start_armed  <= 1'b1;
            type_hi      <= 4'h0;
            type_lo      <= 4'h0;
            mem_ptr      <= {1'b0, MEM_BASE};
            io_ptr       <= {1'b0, IO_BASE};
            base_reg     <= 8'h00;
            ADDRESS      <= 23'd0;
            CPU_RW       <= 1'b1;
            CPU_AS       <= 1'b1;
            CPU_UDS      <= 1'b1;
            DATA_OUT     <= 4'h0;
            DATA_OE      <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            BOARD_COUNT  <= 4'h0;
            SHUTUP_COUNT <= 4'h0;
            PRODUCT      <= 8'h00;
        end else begin
            dtack_m <= DTACK;
            dtack_s <= dtack_m;
            case (state)
                IDLE: begin
                    if (!START) begin
                        start_armed <= 1'b1;
                    end else if (start_armed) begin
                        start_armed  <= 1'b0;
                        BUSY         <= 1'b1;
                        DONE         <= 1'b0;
                        BOARD_COUNT  <= 4'h0;
                        SHUTUP_COUNT <= 4'h0;
                        mem_ptr      <= {1'b0, MEM_BASE};
                        io_ptr       <= {1'b0, IO_BASE};
                        state        <= nxt_state;
                        ADDRESS      <= bus_addr(nxt_state);
                        CPU_RW       <= 1'b1;
                        phase        <= PH_ADDR;
                    end
                end
                ALLOC: begin
                    base_reg <= base[7:0];
                    if (fits) begin
                        if (pool_mem) mem_ptr <= next_ptr;
                        else          io_ptr  <= next_ptr;
                    end
                    state   <= nxt_state;
                    ADDRESS <= bus_addr(nxt_state);
                    CPU_RW  <= !is_write(nxt_state);
                    phase   <= PH_ADDR;
                end
                FIN: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end
                default: begin
                    case (phase)
                        PH_ADDR: begin
                            CPU_AS <= 1'b0;
                            tcnt   <= TW'(1);
                            if (is_write(state)) begin
                                DATA_OE  <= 1'b1;
                                DATA_OUT <= wdata;
                            end
                            phase <= PH_AS;
                        end
                        PH_AS: begin
                            CPU_UDS <= 1'b0;
                            tcnt    <= tcnt + 1'b1;
                            phase   <= PH_UDS;
                        end
                        PH_UDS: begin
                            tcnt  <= tcnt + 1'b1;
                            phase <= PH_WAIT;
                        end
                        PH_WAIT: begin
                            if (!dtack_s) begin
                                timed_out <= 1'b0;
                                CPU_AS    <= 1'b1;
                                CPU_UDS   <= 1'b1;
                                phase     <= PH_NEG;
                                case (state)
                                    RD_T0:   type_hi       <= DATA_IN;
                                    RD_T1:   type_lo       <= DATA_IN;
                                    RD_P0:   PRODUCT[7:4]  <= ~DATA_IN;
                                    RD_P1:   PRODUCT[3:0]  <= ~DATA_IN;
                                    default: ;
                                endcase
                            end else if (tcnt == TIMEOUT_CNT) begin
                                timed_out <= 1'b1;
                                CPU_AS    <= 1'b1;
                                CPU_UDS   <= 1'b1;
                                phase     <= PH_NEG;
                            end else begin
                                tcnt <= tcnt + 1'b1;
                            end
                        end
                        PH_NEG: begin
                            DATA_OE <= 1'b0;
                            CPU_RW  <= 1'b1;
                            phase   <= PH_END;
                        end
                        PH_END: begin
                            if (!timed_out && state == WR_HI)   BOARD_COUNT  <= BOARD_COUNT + 4'd1;
                            if (!timed_out && state == WR_SHUT) SHUTUP_COUNT <= SHUTUP_COUNT + 4'd1;
                            state   <= nxt_state;
                            ADDRESS <= bus_addr(nxt_state);
                            CPU_RW  <= !is_write(nxt_state);
                            phase   <= PH_ADDR;
                        end
                        default: phase <= PH_ADDR;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_autoconfig_master.sv
// Directed bench for autoconfig_master: a behavioural AutoConfig chain answers the bus and logs writes.
module tb_autoconfig_master;

    logic        CPU_CLK = 1'b0;
    logic        RESET   = 1'b0;
    logic        START   = 1'b0;
    logic        DTACK   = 1'b1;
    logic [3:0]  DATA_IN = 4'h0;
    logic [22:0] ADDRESS;
    logic        CPU_RW, CPU_AS, CPU_UDS, CPU_LDS, DATA_OE, BUSY, DONE;
    logic [3:0]  DATA_OUT, BOARD_COUNT, SHUTUP_COUNT;
    logic [7:0]  PRODUCT;

    autoconfig_master dut (
        .CPU_CLK(CPU_CLK), .RESET(RESET), .START(START), .ADDRESS(ADDRESS),
        .CPU_RW(CPU_RW), .CPU_AS(CPU_AS), .CPU_UDS(CPU_UDS), .CPU_LDS(CPU_LDS),
        .DTACK(DTACK), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
        .BUSY(BUSY), .DONE(DONE), .BOARD_COUNT(BOARD_COUNT),
        .SHUTUP_COUNT(SHUTUP_COUNT), .PRODUCT(PRODUCT)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    // Board chain model: only board[board_idx] answers; configuring or shutting it up exposes the next.
    logic [7:0]  b_type [0:7];
    logic [7:0]  b_prod [0:7];
    int          n_boards  = 0;
    int          board_idx = 0;
    logic [22:0] wr_addr [0:15];
    logic [4:0]  wr_data [0:15];
    int          wr_n = 0;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int as_low = 0;

    always @(negedge CPU_CLK) begin
        if (CPU_AS) begin
            DTACK = 1'b1;
        end else if (DTACK && !CPU_UDS && board_idx < n_boards) begin
            DTACK = 1'b0;
            if (CPU_RW) begin
                case (ADDRESS[6:0])
                    7'h00:   DATA_IN = b_type[board_idx][7:4];
                    7'h01:   DATA_IN = b_type[board_idx][3:0];
                    7'h02:   DATA_IN = b_prod[board_idx][7:4];
                    7'h03:   DATA_IN = b_prod[board_idx][3:0];
                    default: DATA_IN = 4'h0;
                endcase
            end else begin
                if (wr_n < 16) begin
                    wr_addr[wr_n] = ADDRESS;
                    wr_data[wr_n] = {DATA_OE, DATA_OUT};
                    wr_n++;
                end
                if (ADDRESS[6:0] == 7'h24 || ADDRESS[6:0] == 7'h26) board_idx++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input int i, input logic [6:0] word, input logic [3:0] d);
        check($sformatf("wr%0d_addr", i), 32'(wr_addr[i]), 32'({8'hE8, 8'h00, word}));
        check($sformatf("wr%0d_data", i), 32'(wr_data[i]), 32'({1'b1, d}));
    endtask

    task automatic set_board(input int i, input logic [7:0] t, input logic [7:0] p);
        b_type[i] = t;
        b_prod[i] = p;
    endtask

    task automatic clear_model();
        n_boards  = 0;
        board_idx = 0;
        wr_n      = 0;
    endtask

    // Starts a run, checks the accept edge, then waits (bounded) for DONE while counting AS-low cycles.
    task automatic run(input string tag, input bit hold_start);
        int cyc;
        @(negedge CPU_CLK);
        START = 1'b1;
        @(posedge CPU_CLK);
        #1;
        check({tag, "_busy_on_start"}, 32'(BUSY), 32'd1);
        check({tag, "_done_cleared"}, 32'(DONE), 32'd0);
        if (!hold_start) begin
            @(negedge CPU_CLK);
            START = 1'b0;
        end
        as_low = 0;
        cyc    = 0;
        while (!DONE && cyc < 5000) begin
            @(negedge CPU_CLK);
            if (!CPU_AS) as_low++;
            cyc++;
        end
        check({tag, "_done"}, 32'(DONE), 32'd1);
        check({tag, "_busy_off"}, 32'(BUSY), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CPU_CLK);
        RESET = 1'b0;
        repeat (2) @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        RESET = 1'b1;
    endtask

    initial begin
        int cyc;

        // Reset state
        repeat (2) @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        check("rst_as", 32'(CPU_AS), 32'd1);
        check("rst_uds", 32'(CPU_UDS), 32'd1);
        check("rst_lds", 32'(CPU_LDS), 32'd1);
        check("rst_rw", 32'(CPU_RW), 32'd1);
        check("rst_addr", 32'(ADDRESS), 32'd0);
        check("rst_dout", 32'(DATA_OUT), 32'd0);
        check("rst_oe", 32'(DATA_OE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_counts", 32'({BOARD_COUNT, SHUTUP_COUNT}), 32'd0);
        RESET = 1'b1;

        // One 1MB memory board, then the chain goes silent
        clear_model();
        set_board(0, 8'hE5, 8'h98);
        n_boards = 1;
        run("t1", 1'b0);
        check("t1_wr_n", 32'(wr_n), 32'd2);
        check_wr(0, 7'h25, 4'h0);
        check_wr(1, 7'h24, 4'h2);
        check("t1_product", 32'(PRODUCT), 32'h67);
        check("t1_boards", 32'(BOARD_COUNT), 32'd1);
        check("t1_shut", 32'(SHUTUP_COUNT), 32'd0);

        // Memory board, two 64K I/O boards, then a $FF terminator
        clear_model();
        set_board(0, 8'hE5, 8'h12);
        set_board(1, 8'hC1, 8'h34);
        set_board(2, 8'hC1, 8'h56);
        set_board(3, 8'hFF, 8'hFF);
        n_boards = 4;
        run("t2", 1'b0);
        check("t2_wr_n", 32'(wr_n), 32'd6);
        check_wr(0, 7'h25, 4'h0);
        check_wr(1, 7'h24, 4'h2);
        check_wr(2, 7'h25, 4'h9);
        check_wr(3, 7'h24, 4'hE);
        check_wr(4, 7'h25, 4'hA);
        check_wr(5, 7'h24, 4'hE);
        check("t2_boards", 32'(BOARD_COUNT), 32'd3);

        // 512K then 1MB: second base aligned up from $28 to $30
        clear_model();
        set_board(0, 8'hE4, 8'h00);
        set_board(1, 8'hE5, 8'h00);
        n_boards = 2;
        run("t3", 1'b0);
        check("t3_wr_n", 32'(wr_n), 32'd4);
        check_wr(0, 7'h25, 4'h0);
        check_wr(1, 7'h24, 4'h2);
        check_wr(2, 7'h25, 4'h0);
        check_wr(3, 7'h24, 4'h3);
        check("t3_mem_ptr", 32'(dut.mem_ptr), 32'h040);
        check("t3_boards", 32'(BOARD_COUNT), 32'd2);

        // Two 8MB boards: second does not fit and is shut up
        clear_model();
        set_board(0, 8'hE0, 8'h00);
        set_board(1, 8'hE0, 8'h00);
        n_boards = 2;
        run("t4", 1'b0);
        check("t4_wr_n", 32'(wr_n), 32'd3);
        check_wr(0, 7'h25, 4'h0);
        check_wr(1, 7'h24, 4'h2);
        check_wr(2, 7'h26, 4'h0);
        check("t4_boards", 32'(BOARD_COUNT), 32'd1);
        check("t4_shut", 32'(SHUTUP_COUNT), 32'd1);

        // No DTACK at all, START held high through the whole run
        clear_model();
        run("t5", 1'b1);
        check("t5_as_low_cycles", 32'(as_low), 32'd64);
        check("t5_counts", 32'({BOARD_COUNT, SHUTUP_COUNT}), 32'd0);
        repeat (5) @(negedge CPU_CLK);
        check("t5_no_retrigger", 32'(BUSY), 32'd0);
        START = 1'b0;

        // RESET during the UDS-assert cycle of WR_HI
        do_reset();
        clear_model();
        set_board(0, 8'hE5, 8'h00);
        n_boards = 1;
        @(negedge CPU_CLK);
        START = 1'b1;
        @(negedge CPU_CLK);
        START = 1'b0;
        cyc = 0;
        while (!(!CPU_UDS && !CPU_RW && ADDRESS[6:0] == 7'h24) && cyc < 500) begin
            @(negedge CPU_CLK);
            cyc++;
        end
        check("t6_reached_wr_hi", 32'(cyc < 500), 32'd1);
        RESET = 1'b0;
        @(posedge CPU_CLK);
        #1;
        check("t6_as", 32'(CPU_AS), 32'd1);
        check("t6_uds", 32'(CPU_UDS), 32'd1);
        check("t6_oe", 32'(DATA_OE), 32'd0);
        check("t6_rw", 32'(CPU_RW), 32'd1);
        check("t6_busy", 32'(BUSY), 32'd0);
        check("t6_boards", 32'(BOARD_COUNT), 32'd0);
        check("t6_idle", 32'(dut.state), 32'd0);
        @(negedge CPU_CLK);
        RESET = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
